dma_ch_dispatch: RTL and testbench

//  Engine-side counterpart of the DMA per-channel OR-merge: takes per-channel requests, grants one channel at a

---
 rtl/dma_pkg.sv | 21 ++
 rtl/dma_rr_pick.sv | 71 +++++++
 rtl/dma_ch_dispatch.sv | 146 ++++++++++++++
 tb/tb_dma_ch_dispatch.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types for the DMA channel dispatcher: dispatch FSM state encoding,
// priority field width and the channel-index width helper.
package dma_pkg;

    // Dispatch sequence: pick a channel, offer it to the engine, wait for completion, pulse done
    typedef enum logic [1:0] {
        DSP_IDLE,
        DSP_REQ,
        DSP_BUSY,
        DSP_DONE
    } dsp_state_e;

    // Width of the per-channel priority field in the packed ch_prio vector
    localparam int PRIO_W = 2;

    // Bits needed to index n channels; never less than one so a 2-channel build still has a real bus
    function automatic int CH_IDX_W(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational channel picker for the DMA dispatcher.
// Scans requesters starting just after rrLast_i and wrapping at N-1 -> 0.
// Build option DMA_CH_PRIO_EN: only requesters at the highest 2-bit priority
// compete, with the same round-robin scan breaking ties. Without it the
// priority input is ignored.
module dma_rr_pick
    import dma_pkg::*;
#(
    parameter int N    = 15,
    parameter int IDXW = CH_IDX_W(N)
) (
    input  logic [N-1:0]        req_i,
    input  logic [IDXW-1:0]     rrLast_i,
    input  logic [PRIO_W*N-1:0] prio_i,
    output logic [N-1:0]        gnt_o,
    output logic [IDXW-1:0]     idx_o,
    output logic                found_o
);

    // One extra bit so rrLast + offset (at most 2N-1) never overflows before the wrap
    localparam int CW = IDXW + 1;

    logic [PRIO_W-1:0] lvl [N];
    logic [PRIO_W-1:0] best;
    logic [CW-1:0]     cand;

`ifdef DMA_CH_PRIO_EN
    // Unpack each channel's priority and find the highest level among active requesters
    always_comb begin
        best = '0;
        for (int i = 0; i < N; i++) begin
            lvl[i] = prio_i[PRIO_W*i +: PRIO_W];
            if (req_i[i] && (lvl[i] > best)) begin
                best = lvl[i];
            end
        end
    end
`else
    // Without priorities every channel sits at level 0, so the scan below is pure round-robin
    logic prio_unused;
    assign prio_unused = ^prio_i;

    // Flatten all levels to zero
    always_comb begin
        best = '0;
        for (int i = 0; i < N; i++) begin
            lvl[i] = '0;
        end
    end
`endif

    // Walk channels rrLast+1, rrLast+2, ... with wrap and take the first one at the winning level
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int off = 1; off <= N; off++) begin
            cand = {1'b0, rrLast_i} + CW'(off);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!found_o && req_i[cand[IDXW-1:0]] && (lvl[cand[IDXW-1:0]] == best)) begin
                found_o                = 1'b1;
                idx_o                  = cand[IDXW-1:0];
                gnt_o[cand[IDXW-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_ch_dispatch.sv
// DMA channel dispatcher: grants one requesting channel at a time to the single
// transfer engine and routes the engine's completion status back to that channel.
// Optional build macro DMA_CH_PRIO_EN enables priority-based selection in the picker.
module dma_ch_dispatch
    import dma_pkg::*;
#(
    parameter int channel_number = 15,
    parameter int width          = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [channel_number-1:0]           ch_req,
    output logic [channel_number-1:0]           ch_gnt,
    output logic [channel_number-1:0]           ch_done,
    output logic [width-1:0]                    ch_status [0:channel_number-1],
    output logic                                eng_valid,
    output logic [CH_IDX_W(channel_number)-1:0] eng_ch,
    input  logic                                eng_ack,
    input  logic                                eng_done,
    input  logic [width-1:0]                    eng_status,
    input  logic [PRIO_W*channel_number-1:0]    ch_prio
);

    localparam int IDXW = CH_IDX_W(channel_number);

    dsp_state_e                state_q, state_d;
    logic [IDXW-1:0]           sel_q, sel_d;
    logic [IDXW-1:0]           rrLast_q, rrLast_d;
    logic [channel_number-1:0] gnt_q, gnt_d;
    logic [channel_number-1:0] done_q, done_d;
    logic                      engValid_q, engValid_d;
    logic [IDXW-1:0]           engCh_q, engCh_d;
    logic [width-1:0]          status_q [0:channel_number-1];
    logic                      statusWe;

    logic [channel_number-1:0] pickGnt;
    logic [IDXW-1:0]           pickIdx;
    logic                      pickFound;

    dma_rr_pick #(
        .N    (channel_number),
        .IDXW (IDXW)
    ) u_pick (
        .req_i    (ch_req),
        .rrLast_i (rrLast_q),
        .prio_i   (ch_prio),
        .gnt_o    (pickGnt),
        .idx_o    (pickIdx),
        .found_o  (pickFound)
    );

    // Next-state logic: the grant is held from selection until the cycle the done pulse goes out
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rrLast_d   = rrLast_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        engValid_d = engValid_q;
        engCh_d    = engCh_q;
        statusWe   = 1'b0;
        case (state_q)
            DSP_IDLE: begin
                if (pickFound) begin
                    sel_d      = pickIdx;
                    gnt_d      = pickGnt;
                    engCh_d    = pickIdx;
                    engValid_d = 1'b1;
                    state_d    = DSP_REQ;
                end
            end
            DSP_REQ: begin
                if (eng_ack) begin
                    engValid_d = 1'b0;
                    if (eng_done) begin
                        statusWe = 1'b1;
                        rrLast_d = sel_q;
                        done_d   = gnt_q;
                        gnt_d    = '0;
                        state_d  = DSP_DONE;
                    end else begin
                        state_d = DSP_BUSY;
                    end
                end else if (!ch_req[sel_q]) begin
                    gnt_d      = '0;
                    engValid_d = 1'b0;
                    state_d    = DSP_IDLE;
                end
            end
            DSP_BUSY: begin
                if (eng_done) begin
                    statusWe = 1'b1;
                    rrLast_d = sel_q;
                    done_d   = gnt_q;
                    gnt_d    = '0;
                    state_d  = DSP_DONE;
                end
            end
            DSP_DONE: begin
                state_d = DSP_IDLE;
            end
            default: begin
                state_d = DSP_IDLE;
            end
        endcase
    end

    // Control and output registers; reset leaves the round-robin pointer on the last channel so channel 0 scans first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DSP_IDLE;
            sel_q      <= '0;
            rrLast_q   <= IDXW'(channel_number - 1);
            gnt_q      <= '0;
            done_q     <= '0;
            engValid_q <= 1'b0;
            engCh_q    <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rrLast_q   <= rrLast_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            engValid_q <= engValid_d;
            engCh_q    <= engCh_d;
        end
    end

    // Per-channel status bank: only the completing channel's entry is written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < channel_number; i++) begin
                status_q[i] <= '0;
            end
        end else if (statusWe) begin
            status_q[sel_q] <= eng_status;
        end
    end

    assign ch_gnt    = gnt_q;
    assign ch_done   = done_q;
    assign ch_status = status_q;
    assign eng_valid = engValid_q;
    assign eng_ch    = engCh_q;

endmodule

// File: tb/tb_dma_ch_dispatch.sv
// Bench for dma_ch_dispatch: stimulus acts as requester and engine, a monitor
// checks grants and done pulses against scoreboard queues filled at issue time.
module tb_dma_ch_dispatch;

    localparam int N = 15;
    localparam int W = 5;
`ifdef DMA_CH_PRIO_EN
    localparam bit PRIO_ON = 1'b1;
`else
    localparam bit PRIO_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   ch_req;
    logic [N-1:0]   ch_gnt;
    logic [N-1:0]   ch_done;
    logic [W-1:0]   ch_status [0:N-1];
    logic           eng_valid;
    logic [3:0]     eng_ch;
    logic           eng_ack;
    logic           eng_done;
    logic [W-1:0]   eng_status;
    logic [2*N-1:0] ch_prio;

    typedef struct {
        int           ch;
        logic [W-1:0] st;
    } done_t;

    int           checks = 0;
    int           errors = 0;
    int           grantQ [$];
    done_t        doneQ [$];
    logic [W-1:0] statusModel [0:N-1];
    int           rrLast;
    logic         prevValid = 1'b0;

    dma_ch_dispatch #(.channel_number(N), .width(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_req     (ch_req),
        .ch_gnt     (ch_gnt),
        .ch_done    (ch_done),
        .ch_status  (ch_status),
        .eng_valid  (eng_valid),
        .eng_ch     (eng_ch),
        .eng_ack    (eng_ack),
        .eng_done   (eng_done),
        .eng_status (eng_status),
        .ch_prio    (ch_prio)
    );

    always #5 clk = ~clk;

    // One comparison: bump the counters and report a mismatch
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference choice: highest priority level present (if enabled), then first such requester after 'last' with wrap
    function automatic int modelPick(input logic [N-1:0] r, input int last, input logic [2*N-1:0] p);
        int best = 0;
        if (PRIO_ON) begin
            for (int i = 0; i < N; i++) begin
                if (r[i] && (int'(2'(p >> (2*i))) > best)) best = int'(2'(p >> (2*i)));
            end
        end
        for (int off = 1; off <= N; off++) begin
            int c = (last + off) % N;
            if (r[c] && (!PRIO_ON || (int'(2'(p >> (2*c))) == best))) return c;
        end
        return -1;
    endfunction

    // Bounded wait for the engine request to appear
    task automatic waitValid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (eng_valid) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL eng_valid_timeout actual=0 expected=1");
    endtask

    task automatic applyReset();
        rst        = 1'b1;
        ch_req     = '0;
        eng_ack    = 1'b0;
        eng_done   = 1'b0;
        eng_status = '0;
        ch_prio    = '0;
        for (int i = 0; i < N; i++) statusModel[i] = '0;
        rrLast = N - 1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_gnt", 32'(ch_gnt), 0);
        checkOutput("reset_done", 32'(ch_done), 0);
        checkOutput("reset_valid", 32'(eng_valid), 0);
        checkOutput("reset_eng_ch", 32'(eng_ch), 0);
        for (int i = 0; i < N; i++) checkOutput($sformatf("reset_status%0d", i), 32'(ch_status[i]), 0);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // One complete transfer: request, engine ack after ackDly, done after doneDly (or together with ack)
    task automatic applyStimulus(input logic [N-1:0] req, input int ackDly, input int doneDly,
                                 input logic [W-1:0] st, input bit together, input bit keep);
        int  expCh;
        bit  ok;
        done_t d;
        expCh = modelPick(req, rrLast, ch_prio);
        d.ch  = expCh;
        d.st  = st;
        grantQ.push_back(expCh);
        doneQ.push_back(d);
        ch_req = req;
        waitValid(ok);
        if (!ok) begin
            void'(grantQ.pop_back());
            void'(doneQ.pop_back());
            ch_req = '0;
            return;
        end
        repeat (ackDly) begin @(posedge clk); #1; end
        eng_ack = 1'b1;
        if (together) begin
            eng_done   = 1'b1;
            eng_status = st;
        end
        @(posedge clk); #1;
        eng_ack  = 1'b0;
        eng_done = 1'b0;
        if (!together) begin
            repeat (doneDly) begin @(posedge clk); #1; end
            eng_done   = 1'b1;
            eng_status = st;
            @(posedge clk); #1;
            eng_done = 1'b0;
        end
        rrLast = expCh;
        if (!keep) ch_req = '0;
        @(posedge clk); #1;
    endtask

    // Monitor: checks each new engine request and each done pulse against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (eng_valid && !prevValid) begin
                if (grantQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_grant actual=%0d expected=none", eng_ch);
                end else begin
                    int g;
                    g = grantQ.pop_front();
                    checkOutput("grant_eng_ch", 32'(eng_ch), 32'(g));
                    checkOutput("grant_onehot", 32'(ch_gnt), 32'(1) << g);
                end
            end
            if (ch_done != '0) begin
                if (doneQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done actual=0x%0h expected=0", ch_done);
                end else begin
                    done_t d;
                    d = doneQ.pop_front();
                    statusModel[d.ch] = d.st;
                    checkOutput("done_onehot", 32'(ch_done), 32'(1) << d.ch);
                    checkOutput("done_gnt_clear", 32'(ch_gnt), 0);
                    for (int i = 0; i < N; i++)
                        checkOutput($sformatf("status_ch%0d", i), 32'(ch_status[i]), 32'(statusModel[i]));
                end
            end
        end
        prevValid = rst ? 1'b0 : eng_valid;
    end

    // Global time limit
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        bit ok;
        applyReset();

        // Single requester ch2 with delayed ack and done
        applyStimulus(15'h0004, 2, 3, 5'h11, 1'b0, 1'b0);

        // All channels requesting and held: full rotation plus wrap
        for (int k = 0; k < 16; k++) applyStimulus(15'h7FFF, 0, 0, W'(k + 1), 1'b1, 1'b1);
        ch_req = '0;
        repeat (3) @(posedge clk);
        #1;

        // Ack and done in the same cycle on ch7
        applyStimulus(15'h0080, 0, 0, 5'h1F, 1'b1, 1'b0);

        // Engine strobes while idle must be ignored
        eng_ack    = 1'b1;
        eng_done   = 1'b1;
        eng_status = 5'h0A;
        @(posedge clk); #1;
        eng_ack  = 1'b0;
        eng_done = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_strobe_valid", 32'(eng_valid), 0);

        // Request withdrawn before ack: grant dropped, pointer untouched
        applyReset();
        grantQ.push_back(modelPick(15'h0008, rrLast, ch_prio));
        ch_req = 15'h0008;
        waitValid(ok);
        @(posedge clk); #1;
        ch_req = '0;
        @(posedge clk); #1;
        checkOutput("abort_valid", 32'(eng_valid), 0);
        checkOutput("abort_gnt", 32'(ch_gnt), 0);
        applyStimulus(15'h0009, 1, 1, 5'h03, 1'b0, 1'b0);

        // Priority case: ch0 at 1, ch3 at 3
        ch_prio = '0;
        ch_prio[1:0] = 2'd1;
        ch_prio[7:6] = 2'd3;
        applyStimulus(15'h0009, 0, 1, 5'h07, 1'b0, 1'b0);
        ch_prio[1:0] = 2'd3;
        applyStimulus(15'h0009, 0, 1, 5'h08, 1'b0, 1'b0);
        applyStimulus(15'h0009, 0, 1, 5'h09, 1'b0, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            ch_prio = 30'($urandom);
            applyStimulus(15'($urandom_range(1, 32767)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), 5'($urandom), 1'($urandom), 1'b0);
        end

        // Reset while ch5 is busy: everything back to reset values at once
        ch_prio = '0;
        grantQ.push_back(modelPick(15'h0020, rrLast, ch_prio));
        ch_req = 15'h0020;
        waitValid(ok);
        eng_ack = 1'b1;
        @(posedge clk); #1;
        eng_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_gnt", 32'(ch_gnt), 0);
        checkOutput("midrst_done", 32'(ch_done), 0);
        checkOutput("midrst_valid", 32'(eng_valid), 0);
        checkOutput("midrst_eng_ch", 32'(eng_ch), 0);
        for (int i = 0; i < N; i++) checkOutput($sformatf("midrst_status%0d", i), 32'(ch_status[i]), 0);
        ch_req = '0;
        for (int i = 0; i < N; i++) statusModel[i] = '0;
        rrLast = N - 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(15'h0120, 1, 2, 5'h15, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("grant_queue_empty", 32'(grantQ.size()), 0);
        checkOutput("done_queue_empty", 32'(doneQ.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
